load_align_unit: RTL and testbench
==================================

Name: load_align_unit

Overview:
Sequential load unit, successor to the combinational load extractor. Accepts a load request (address, size, sign mode) and issues word-aligned reads to data memory over a valid handshake with variable latency. Extracts and extends the addressed byte, half or word, and returns the result with a one-cycle response strobe. Sits between the execute stage and data memory; its response feeds register writeback.

Parameters:
XLEN, 32, data/word width in bits; legal values 32 or 64.
ADDR_W, 32, byte-address width.
OFF_W, localparam = log2(XLEN/8), byte-offset width within one word.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
req_valid  in  1  load request present.
req_ready  out  1  unit can accept a request (IDLE only).
req_addr  in  ADDR_W  byte address.
req_size  in  2  00 byte, 01 half, 10 word(32), 11 dword (XLEN=64 only).
req_unsigned  in  1  1 = zero-extend, 0 = sign-extend.
mem_rd_en  out  1  one-cycle read strobe.
mem_addr  out  ADDR_W  word-aligned read address (low OFF_W bits zero).
mem_rd_data  in  XLEN  read data.
mem_rd_valid  in  1  mem_rd_data valid this cycle.
rsp_valid  out  1  one-cycle result strobe.
rsp_data  out  XLEN  extended load result.
rsp_err  out  1  misaligned-access error, qualified by rsp_valid.

Behaviour:
- Clock and reset: one clock clk; reset rst is synchronous and active-high.
- Reset values: req_ready=1, mem_rd_en=0, mem_addr=0, rsp_valid=0, rsp_data=0, rsp_err=0, state=IDLE.
- FSM states: IDLE, ISSUE0, WAIT0, ISSUE1, WAIT1, RESP.
- IDLE: req_ready=1. On req_valid, latch addr, size and unsigned, then go to ISSUE0.
- ISSUE0: mem_rd_en=1 for exactly one cycle; mem_addr = addr with the low OFF_W bits cleared. Go to WAIT0.
- WAIT0: hold until mem_rd_valid, then latch word0.
  - If the access crosses a word boundary (offset + bytes > XLEN/8) and the split feature is enabled, go to ISSUE1.
  - Otherwise go to RESP.
- ISSUE1: mem_rd_en=1 for one cycle; mem_addr = aligned addr + XLEN/8, wrapping modulo 2^ADDR_W. Go to WAIT1.
- WAIT1: on mem_rd_valid, latch word1 and go to RESP.
- RESP: rsp_valid=1 for one cycle, then return to IDLE. rsp_data and rsp_err hold until the next RESP.
- Extraction: form {word1,word0} (word1=0 for a single read) and shift right by 8*offset. Take the low 8/16/32/64 bits and sign- or zero-extend to XLEN.
- Minimum latency (aligned access, zero-wait memory that asserts mem_rd_valid in the cycle after mem_rd_en): request accepted at cycle N, rsp_valid at N+3.
- Split access adds 2 cycles plus the second memory wait.
- req_size=11 with XLEN=32: rsp_err=1, rsp_data=0; no memory read is issued (ISSUE0 skips straight to RESP).
- mem_rd_valid is ignored outside WAIT0/WAIT1; stray strobes must not corrupt state.
- rst asserted mid-operation: abandon the transaction and return to IDLE next cycle; no rsp_valid. A late mem_rd_valid is ignored.
- req_valid outside IDLE is ignored; the requester must hold it until req_ready.

Optional Feature:
MISALIGNED_SPLIT_EN.
- Defined: boundary-crossing accesses use two reads merged as above; rsp_err=0.
- Undefined: ISSUE1/WAIT1 are not generated. Crossing accesses perform the first read only, then RESP with rsp_err=1, rsp_data=0.

Decomposition:
- Shared package load_pkg:
  - size encodings (SZ_B, SZ_H, SZ_W, SZ_D) and FSM state enum;
  - function bytes_of(size).
- One sub-module, load_extract: combinational shift, mask and sign/zero extension of the {word1,word0} window, parametrised by XLEN. Reusable by the store path for testing.

Test Plan:
- XLEN=32, word @0x100 = 0xA14BC5F3, size=10, offset 0 -> rsp_data 0xA14BC5F3, rsp_err 0, rsp_valid 3 cycles after accept.
- Byte, offsets 0..3, signed -> 0xFFFFFFF3, 0xFFFFFFC5, 0x0000004B, 0xFFFFFFA1. Offset 3 unsigned -> 0x000000A1.
- Half @0x102 signed -> 0xFFFFA14B; half @0x101 signed -> 0x00004BC5.
- Split enabled, word @0x104 = 0x11223344:
  - word @0x101 -> 0x44A14BC5; mem_addr sequence 0x100 then 0x104.
  - half @0x103 unsigned -> 0x000044A1.
  - Without the macro: both -> rsp_err 1, rsp_data 0.
- Memory wait of 5 cycles plus a stray mem_rd_valid in IDLE -> correct data once, no extra rsp_valid.
- rst pulsed during WAIT0, then mem_rd_valid -> no rsp_valid; req_ready=1 the cycle after reset. The next request completes normally.

Source files
------------

// File: rtl/load_pkg.sv
// Shared encodings for the load path: access sizes, load FSM states and a
// size-to-byte-count helper.
package load_pkg;

  typedef enum logic [1:0] {
    SZ_B = 2'b00,
    SZ_H = 2'b01,
    SZ_W = 2'b10,
    SZ_D = 2'b11
  } size_t;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ISSUE0 = 3'd1,
    WAIT0  = 3'd2,
    ISSUE1 = 3'd3,
    WAIT1  = 3'd4,
    RESP   = 3'd5
  } state_t;

  function automatic logic [3:0] bytes_of(input size_t size);
    logic [3:0] n;
    case (size)
      SZ_B:    n = 4'd1;
      SZ_H:    n = 4'd2;
      SZ_W:    n = 4'd4;
      SZ_D:    n = 4'd8;
      default: n = 4'd1;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/load_extract.sv
// Combinational extractor: shifts the {word1,word0} window down by the byte
// offset, keeps the addressed byte/half/word/dword and sign- or zero-extends it.
module load_extract
  import load_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int OFF_W = $clog2(XLEN / 8)
) (
  input  logic [XLEN-1:0]  word0,
  input  logic [XLEN-1:0]  word1,
  input  logic [OFF_W-1:0] offset,
  input  size_t            size,
  input  logic             is_unsigned,
  output logic [XLEN-1:0]  data
);

  logic [2*XLEN-1:0] window_s;
  logic [2*XLEN-1:0] shifted_s;
  logic [6:0]        nbits_s;
  logic              sign_s;
  logic              fill_s;

  // Shift, pick the top bit of the field, then fill everything above the field
  always_comb begin
    window_s  = {word1, word0};
    shifted_s = window_s >> {offset, 3'b000};
    nbits_s   = {bytes_of(size), 3'b000};
    case (size)
      SZ_B:    sign_s = shifted_s[7];
      SZ_H:    sign_s = shifted_s[15];
      SZ_W:    sign_s = shifted_s[31];
      SZ_D:    sign_s = shifted_s[63];
      default: sign_s = 1'b0;
    endcase
    if (is_unsigned) begin
      fill_s = 1'b0;
    end else begin
      fill_s = sign_s;
    end
    data = {XLEN{1'b0}};
    for (int i = 0; i < XLEN; i++) begin
      if (i < int'(nbits_s)) begin
        data[i] = shifted_s[i];
      end else begin
        data[i] = fill_s;
      end
    end
  end

endmodule

// File: rtl/load_align_unit.sv
// Sequential load unit: word-aligned reads over a valid handshake, then extract
// and extend. Define MISALIGNED_SPLIT_EN to merge two reads for crossing loads.
module load_align_unit
  import load_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [XLEN-1:0]   mem_rd_data,
  input  logic              mem_rd_valid,
  output logic              rsp_valid,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_err
);

  localparam int OFF_W      = $clog2(XLEN / 8);
  localparam int WORD_BYTES = XLEN / 8;

  state_t            state_r;
  state_t            state_next_s;
  logic [ADDR_W-1:0] addr_r;
  size_t             size_r;
  logic              unsigned_r;
  logic [XLEN-1:0]   word0_r;
  logic [OFF_W-1:0]  off_s;
  logic              cross_s;
  logic              err_next_s;
  logic [XLEN-1:0]   ext_w0_s;
  logic [XLEN-1:0]   ext_w1_s;
  logic [XLEN-1:0]   ext_data_s;
  logic [ADDR_W-1:0] req_aligned_s;
  logic [ADDR_W-1:0] next_aligned_s;

  // Dword loads only exist on a 64-bit datapath
  function automatic logic size_bad(input size_t sz);
    return (sz == SZ_D) && (XLEN < 64);
  endfunction

  // Address arithmetic and extractor window; the arriving word is used directly
  // so the result is ready in the same cycle the FSM enters RESP
  always_comb begin
    off_s          = addr_r[OFF_W-1:0];
    cross_s        = (5'(off_s) + 5'(bytes_of(size_r))) > 5'(WORD_BYTES);
    req_aligned_s  = {req_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    next_aligned_s = {addr_r[ADDR_W-1:OFF_W], {OFF_W{1'b0}}} + ADDR_W'(WORD_BYTES);
    if (state_r == WAIT0) begin
      ext_w0_s = mem_rd_data;
    end else begin
      ext_w0_s = word0_r;
    end
    if (state_r == WAIT1) begin
      ext_w1_s = mem_rd_data;
    end else begin
      ext_w1_s = {XLEN{1'b0}};
    end
  end

  load_extract #(.XLEN(XLEN), .OFF_W(OFF_W)) u_extract (
    .word0       (ext_w0_s),
    .word1       (ext_w1_s),
    .offset      (off_s),
    .size        (size_r),
    .is_unsigned (unsigned_r),
    .data        (ext_data_s)
  );

  // Next-state logic; err_next_s marks entries into RESP that report an error
  always_comb begin
    state_next_s = state_r;
    err_next_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_valid) state_next_s = ISSUE0;
        else           state_next_s = IDLE;
      end
      ISSUE0: begin
        if (size_bad(size_r)) begin
          state_next_s = RESP;
          err_next_s   = 1'b1;
        end else begin
          state_next_s = WAIT0;
        end
      end
      WAIT0: begin
        if (!mem_rd_valid) begin
          state_next_s = WAIT0;
        end else if (!cross_s) begin
          state_next_s = RESP;
        end else begin
`ifdef MISALIGNED_SPLIT_EN
          state_next_s = ISSUE1;
`else
          state_next_s = RESP;
          err_next_s   = 1'b1;
`endif
        end
      end
`ifdef MISALIGNED_SPLIT_EN
      ISSUE1: state_next_s = WAIT1;
      WAIT1: begin
        if (mem_rd_valid) state_next_s = RESP;
        else              state_next_s = WAIT1;
      end
`endif
      RESP:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register, request/word latches and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      req_ready  <= 1'b1;
      mem_rd_en  <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      rsp_valid  <= 1'b0;
      rsp_data   <= {XLEN{1'b0}};
      rsp_err    <= 1'b0;
      addr_r     <= {ADDR_W{1'b0}};
      size_r     <= SZ_B;
      unsigned_r <= 1'b0;
      word0_r    <= {XLEN{1'b0}};
    end else begin
      state_r   <= state_next_s;
      req_ready <= (state_next_s == IDLE);
      mem_rd_en <= ((state_next_s == ISSUE0) && !size_bad(size_t'(req_size))) ||
                   (state_next_s == ISSUE1);
      rsp_valid <= (state_next_s == RESP);
      if ((state_r == IDLE) && req_valid) begin
        addr_r     <= req_addr;
        size_r     <= size_t'(req_size);
        unsigned_r <= req_unsigned;
        mem_addr   <= req_aligned_s;
      end else if (state_next_s == ISSUE1) begin
        mem_addr   <= next_aligned_s;
      end
      if ((state_r == WAIT0) && mem_rd_valid) begin
        word0_r <= mem_rd_data;
      end
      if (state_next_s == RESP) begin
        rsp_data <= err_next_s ? {XLEN{1'b0}} : ext_data_s;
        rsp_err  <= err_next_s;
      end
    end
  end

endmodule

// File: tb/tb_load_align_unit.sv
// Directed bench for load_align_unit (XLEN=32) with a variable-latency memory
// responder; crossing-load expectations follow MISALIGNED_SPLIT_EN.
module tb_load_align_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        mem_rd_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_rd_data;
  logic        mem_rd_valid;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;

  int          n_vec = 0;
  int          n_err = 0;
  int          mem_lat = 0;
  int          rd_count = 0;
  int          rsp_count = 0;
  logic [31:0] rd_log [0:255];
  logic        mem_valid_q = 1'b0;
  logic [31:0] data_q = 32'h0;
  logic        stray_valid = 1'b0;
  logic        pend_q = 1'b0;
  int          cnt_q = 0;
  logic [31:0] paddr_q = 32'h0;

  always #5 clk = ~clk;

  load_align_unit dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_addr     (req_addr),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .mem_rd_en    (mem_rd_en),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_rd_valid (mem_rd_valid),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err)
  );

  assign mem_rd_valid = mem_valid_q | stray_valid;
  assign mem_rd_data  = mem_valid_q ? data_q : 32'hBAD0BAD0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hA14BC5F3;
      32'h0000_0104: return 32'h11223344;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  // Memory: answers each read after mem_lat extra cycles
  always @(posedge clk) begin
    mem_valid_q <= 1'b0;
    if (mem_rd_en) begin
      if (mem_lat == 0) begin
        mem_valid_q <= 1'b1;
        data_q      <= mem_word(mem_addr);
      end else begin
        pend_q  <= 1'b1;
        cnt_q   <= mem_lat - 1;
        paddr_q <= mem_addr;
      end
    end else if (pend_q) begin
      if (cnt_q == 0) begin
        mem_valid_q <= 1'b1;
        data_q      <= mem_word(paddr_q);
        pend_q      <= 1'b0;
      end else begin
        cnt_q <= cnt_q - 1;
      end
    end
  end

  // Monitors: read strobes with their addresses, and response strobes
  always @(posedge clk) begin
    if (mem_rd_en) begin
      rd_log[rd_count & 255] <= mem_addr;
      rd_count <= rd_count + 1;
    end
    if (rsp_valid) rsp_count <= rsp_count + 1;
  end

  task automatic check(input logic [63:0] obs, input logic [63:0] expv, input string tag);
    n_vec++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic run_load(input logic [31:0] a, input logic [1:0] sz, input logic u,
                          input logic [31:0] exp_d, input logic exp_e, input int exp_lat,
                          input int exp_reads, input logic [31:0] exp_a0,
                          input logic [31:0] exp_a1, input string tag);
    int start_rd;
    int start_rsp;
    int cyc;
    @(negedge clk);
    check({63'd0, req_ready}, 64'd1, {tag, " ready"});
    req_valid    = 1'b1;
    req_addr     = a;
    req_size     = sz;
    req_unsigned = u;
    start_rd     = rd_count;
    start_rsp    = rsp_count;
    @(negedge clk);
    req_valid = 1'b0;
    cyc = 1;
    while (!rsp_valid && cyc < 60) begin
      @(negedge clk);
      cyc++;
    end
    check(64'(cyc), 64'(exp_lat), {tag, " latency"});
    check({32'd0, rsp_data}, {32'd0, exp_d}, {tag, " data"});
    check({63'd0, rsp_err}, {63'd0, exp_e}, {tag, " err"});
    @(negedge clk);
    check({63'd0, rsp_valid}, 64'd0, {tag, " strobe one cycle"});
    check({32'd0, rsp_data}, {32'd0, exp_d}, {tag, " data hold"});
    check(64'(rsp_count - start_rsp), 64'd1, {tag, " rsp count"});
    check(64'(rd_count - start_rd), 64'(exp_reads), {tag, " reads"});
    if (exp_reads > 0) check({32'd0, rd_log[start_rd & 255]}, {32'd0, exp_a0}, {tag, " addr0"});
    if (exp_reads > 1) check({32'd0, rd_log[(start_rd + 1) & 255]}, {32'd0, exp_a1}, {tag, " addr1"});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int start_rsp;
    rst          = 1'b1;
    req_valid    = 1'b0;
    req_addr     = 32'h0;
    req_size     = 2'b00;
    req_unsigned = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check({63'd0, req_ready}, 64'd1, "reset req_ready");
    check({63'd0, mem_rd_en}, 64'd0, "reset mem_rd_en");
    check({32'd0, mem_addr}, 64'd0, "reset mem_addr");
    check({63'd0, rsp_valid}, 64'd0, "reset rsp_valid");
    check({32'd0, rsp_data}, 64'd0, "reset rsp_data");
    check({63'd0, rsp_err}, 64'd0, "reset rsp_err");

    // Aligned word, bytes at each offset, halves
    run_load(32'h100, 2'b10, 1'b0, 32'hA14BC5F3, 1'b0, 3, 1, 32'h100, 32'h0, "word@100");
    run_load(32'h100, 2'b00, 1'b0, 32'hFFFFFFF3, 1'b0, 3, 1, 32'h100, 32'h0, "byte@100");
    run_load(32'h101, 2'b00, 1'b0, 32'hFFFFFFC5, 1'b0, 3, 1, 32'h100, 32'h0, "byte@101");
    run_load(32'h102, 2'b00, 1'b0, 32'h0000004B, 1'b0, 3, 1, 32'h100, 32'h0, "byte@102");
    run_load(32'h103, 2'b00, 1'b0, 32'hFFFFFFA1, 1'b0, 3, 1, 32'h100, 32'h0, "byte@103");
    run_load(32'h103, 2'b00, 1'b1, 32'h000000A1, 1'b0, 3, 1, 32'h100, 32'h0, "ubyte@103");
    run_load(32'h102, 2'b01, 1'b0, 32'hFFFFA14B, 1'b0, 3, 1, 32'h100, 32'h0, "half@102");
    run_load(32'h101, 2'b01, 1'b0, 32'h00004BC5, 1'b0, 3, 1, 32'h100, 32'h0, "half@101");

    // Word-boundary crossing loads
`ifdef MISALIGNED_SPLIT_EN
    run_load(32'h101, 2'b10, 1'b0, 32'h44A14BC5, 1'b0, 5, 2, 32'h100, 32'h104, "split word@101");
    run_load(32'h103, 2'b01, 1'b1, 32'h000044A1, 1'b0, 5, 2, 32'h100, 32'h104, "split uhalf@103");
`else
    run_load(32'h101, 2'b10, 1'b0, 32'h00000000, 1'b1, 3, 1, 32'h100, 32'h0, "cross word@101");
    run_load(32'h103, 2'b01, 1'b1, 32'h00000000, 1'b1, 3, 1, 32'h100, 32'h0, "cross uhalf@103");
`endif

    // Dword on a 32-bit unit: error with no read
    run_load(32'h100, 2'b11, 1'b0, 32'h00000000, 1'b1, 2, 0, 32'h0, 32'h0, "dword err");

    // Stray read-valid in IDLE, then a slow memory
    start_rsp = rsp_count;
    @(negedge clk);
    stray_valid = 1'b1;
    @(negedge clk);
    stray_valid = 1'b0;
    @(negedge clk);
    check({63'd0, rsp_valid}, 64'd0, "stray no rsp_valid");
    check({63'd0, req_ready}, 64'd1, "stray still idle");
    check(64'(rsp_count - start_rsp), 64'd0, "stray rsp count");
    mem_lat = 5;
    run_load(32'h101, 2'b00, 1'b1, 32'h000000C5, 1'b0, 8, 1, 32'h100, 32'h0, "slow ubyte@101");
    repeat (4) @(negedge clk);
    check(64'(rsp_count - start_rsp), 64'd1, "slow single response");

    // Reset during WAIT0; the late read-valid must be ignored
    mem_lat = 4;
    @(negedge clk);
    start_rsp    = rsp_count;
    req_valid    = 1'b1;
    req_addr     = 32'h100;
    req_size     = 2'b10;
    req_unsigned = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check({63'd0, req_ready}, 64'd1, "rst req_ready");
    check({63'd0, rsp_valid}, 64'd0, "rst rsp_valid");
    check({32'd0, rsp_data}, 64'd0, "rst rsp_data");
    repeat (8) @(negedge clk);
    check(64'(rsp_count - start_rsp), 64'd0, "rst no response");
    check({63'd0, req_ready}, 64'd1, "rst late valid ignored");
    mem_lat = 0;
    run_load(32'h100, 2'b10, 1'b0, 32'hA14BC5F3, 1'b0, 3, 1, 32'h100, 32'h0, "after rst word");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
